// File: rtl/conv_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_loop_sequencer : z/y/fy/x loop controller for one conv layer with     |
// | double-buffered ifm/filter chunk prefetch.            Revision 1.0         |
// +--------------------------------------------------------------------------+
module conv_loop_sequencer #(
  parameter int FILTER_SIZE_X       = 3,
  parameter int OUTPUT_SIZE_X       = 4,
  parameter int CHANNEL_NUM         = 64,
  parameter int DIVIDED_CHANNEL_NUM = 32,
  parameter int WR_DAT_CYC_NUM      = 8,
  parameter int RD_DAT_CYC_NUM      = 32,
  parameter int OUTPUT_BUF_NUM      = 16,
  parameter int SRAM_IFM_NUM        = 64,
  parameter int SRAM_FILTER_NUM     = 16,
  parameter int FILTER_SIZE_MAX     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 total_chunk_end_i,
  output logic                                 ifm_chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]    ifm_chunk_wr_count_o,
  output logic                                 ifm_chunk_wr_sel_o,
  output logic                                 ifm_chunk_rd_sel_o,
  output logic [$clog2(SRAM_IFM_NUM)-1:0]      ifm_sram_rd_count_o,
  output logic                                 filter_chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]    filter_chunk_wr_count_o,
  output logic                                 filter_chunk_wr_sel_o,
  output logic                                 filter_chunk_rd_sel_o,
  output logic [$clog2(SRAM_FILTER_NUM)-1:0]   filter_sram_rd_count_o,
  output logic                                 run_valid_o,
  output logic                                 total_chunk_start_o,
  output logic [$clog2(RD_DAT_CYC_NUM)-1:0]    rd_ifm_sparsemap_first_o,
  output logic [$clog2(RD_DAT_CYC_NUM)-1:0]    rd_ifm_sparsemap_next_o,
  output logic [$clog2(RD_DAT_CYC_NUM)-1:0]    rd_fil_sparsemap_first_o,
  output logic [$clog2(RD_DAT_CYC_NUM)-1:0]    rd_fil_sparsemap_last_o,
  output logic [$clog2(FILTER_SIZE_MAX)-1:0]   rd_fil_nonzero_dat_first_o,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]    acc_buf_sel_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int FS    = FILTER_SIZE_X;
  localparam int OS    = OUTPUT_SIZE_X;
  localparam int Z_NUM = (CHANNEL_NUM + DIVIDED_CHANNEL_NUM - 1) / DIVIDED_CHANNEL_NUM;
  localparam int Y_NUM = FS + OS - 1;

  localparam int WCW = $clog2(WR_DAT_CYC_NUM);
  localparam int IFW = $clog2(SRAM_IFM_NUM);
  localparam int FLW = $clog2(SRAM_FILTER_NUM);
  localparam int RDW = $clog2(RD_DAT_CYC_NUM);
  localparam int NZW = $clog2(FILTER_SIZE_MAX);
  localparam int ACW = $clog2(OUTPUT_BUF_NUM);
  localparam int ZW  = (Z_NUM > 1) ? $clog2(Z_NUM) : 1;
  localparam int YW  = (Y_NUM > 1) ? $clog2(Y_NUM) : 1;
  localparam int FYW = (FS > 1) ? $clog2(FS) : 1;
  localparam int XW  = (OS > 1) ? $clog2(OS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_SWAP    = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_ROWWAIT = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  // First/last filter row that contributes to ifm row y
  function automatic int fy_lo(input int y);
    return (y > OS - 1) ? (y - OS + 1) : 0;
  endfunction

  function automatic int fy_hi(input int y);
    return (y < FS - 1) ? y : (FS - 1);
  endfunction

  state_e           state_q, state_d;
  logic [ZW-1:0]    z_q, z_d;
  logic [YW-1:0]    y_q, y_d;
  logic [FYW-1:0]   fy_q, fy_d;
  logic [XW-1:0]    x_q, x_d;

  logic             ifm_wr_valid_q, ifm_wr_valid_d;
  logic [WCW-1:0]   ifm_wr_count_q, ifm_wr_count_d;
  logic [IFW-1:0]   ifm_sram_q, ifm_sram_d;
  logic             fil_wr_valid_q, fil_wr_valid_d;
  logic [WCW-1:0]   fil_wr_count_q, fil_wr_count_d;
  logic [FLW-1:0]   fil_sram_q, fil_sram_d;
  logic             ifm_rd_sel_q, ifm_rd_sel_d;
  logic             fil_rd_sel_q, fil_rd_sel_d;

  logic             run_valid_q, run_valid_d;
  logic [RDW-1:0]   ifm_first_q, ifm_first_d;
  logic [RDW-1:0]   ifm_next_q, ifm_next_d;
  logic [RDW-1:0]   fil_first_q, fil_first_d;
  logic [RDW-1:0]   fil_last_q, fil_last_d;
  logic [NZW-1:0]   nz_first_q, nz_first_d;
  logic [ACW-1:0]   acc_sel_q, acc_sel_d;

  logic             row_last, layer_last, last_zy, bursts_idle;
  logic             ifm_start, fil_start;
  logic [IFW-1:0]   ifm_src;
  logic [FLW-1:0]   fil_src;

  assign bursts_idle = !ifm_wr_valid_q && !fil_wr_valid_q;
  assign row_last    = (int'(x_q) == OS - 1) && (int'(fy_q) == fy_hi(int'(y_q)));
  assign last_zy     = (int'(y_q) == Y_NUM - 1) && (int'(z_q) == Z_NUM - 1);
  assign layer_last  = row_last && last_zy;

  // Loop nest and control FSM
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    y_d     = y_q;
    fy_d    = fy_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PRELOAD;
          z_d     = '0;
          y_d     = '0;
          fy_d    = '0;
          x_d     = '0;
        end
      end
      S_PRELOAD: if (bursts_idle) state_d = S_SWAP;
      S_SWAP:    state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (total_chunk_end_i) begin
          if (layer_last) begin
            state_d = S_DONE;
            z_d     = '0;
            y_d     = '0;
            fy_d    = '0;
            x_d     = '0;
          end else if (row_last) begin
            state_d = S_ROWWAIT;
            x_d     = '0;
            if (int'(y_q) == Y_NUM - 1) begin
              y_d  = '0;
              fy_d = '0;
              z_d  = z_q + ZW'(1);
            end else begin
              y_d  = y_q + YW'(1);
              fy_d = FYW'(fy_lo(int'(y_q) + 1));
            end
          end else begin
            state_d = S_ISSUE;
            if (int'(x_q) == OS - 1) begin
              x_d  = '0;
              fy_d = fy_q + FYW'(1);
            end else begin
              x_d  = x_q + XW'(1);
            end
          end
        end
      end
      S_ROWWAIT: if (bursts_idle) state_d = S_SWAP;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Prefetch launches on the SWAP->ISSUE edge, after rd_sel has moved off the target buffer
  always_comb begin
    ifm_start = 1'b0;
    fil_start = 1'b0;
    ifm_src   = '0;
    fil_src   = '0;
    if (state_q == S_IDLE && start_i) begin
      ifm_start = 1'b1;
      fil_start = 1'b1;
    end else if (state_q == S_SWAP) begin
      ifm_start = !last_zy;
      ifm_src   = IFW'(int'(z_q) * Y_NUM + int'(y_q) + 1);
      fil_start = (y_q == '0) && (int'(z_q) < Z_NUM - 1);
      fil_src   = FLW'(int'(z_q) + 1);
    end
  end

  always_comb begin
    ifm_wr_valid_d = ifm_wr_valid_q;
    ifm_wr_count_d = ifm_wr_count_q;
    ifm_sram_d     = ifm_sram_q;
    if (ifm_start) begin
      ifm_wr_valid_d = 1'b1;
      ifm_wr_count_d = '0;
      ifm_sram_d     = ifm_src;
    end else if (ifm_wr_valid_q) begin
      if (int'(ifm_wr_count_q) == WR_DAT_CYC_NUM - 1) begin
        ifm_wr_valid_d = 1'b0;
        ifm_wr_count_d = '0;
      end else begin
        ifm_wr_count_d = ifm_wr_count_q + WCW'(1);
      end
    end
  end

  always_comb begin
    fil_wr_valid_d = fil_wr_valid_q;
    fil_wr_count_d = fil_wr_count_q;
    fil_sram_d     = fil_sram_q;
    if (fil_start) begin
      fil_wr_valid_d = 1'b1;
      fil_wr_count_d = '0;
      fil_sram_d     = fil_src;
    end else if (fil_wr_valid_q) begin
      if (int'(fil_wr_count_q) == WR_DAT_CYC_NUM - 1) begin
        fil_wr_valid_d = 1'b0;
        fil_wr_count_d = '0;
      end else begin
        fil_wr_count_d = fil_wr_count_q + WCW'(1);
      end
    end
  end

  // Filter buffer only flips when a new z begins (y wraps to 0), including the preload
  always_comb begin
    ifm_rd_sel_d = ifm_rd_sel_q ^ (state_q == S_SWAP);
    fil_rd_sel_d = fil_rd_sel_q ^ ((state_q == S_SWAP) && (y_q == '0));
    run_valid_d  = run_valid_q;
    if (state_d == S_ISSUE) begin
      run_valid_d = 1'b1;
    end else if (state_d == S_DONE || state_d == S_IDLE) begin
      run_valid_d = 1'b0;
    end
  end

  // Pass descriptors are captured from the loop indices of the pass about to issue
  always_comb begin
    ifm_first_d = ifm_first_q;
    ifm_next_d  = ifm_next_q;
    fil_first_d = fil_first_q;
    fil_last_d  = fil_last_q;
    nz_first_d  = nz_first_q;
    acc_sel_d   = acc_sel_q;
    if (state_d == S_ISSUE) begin
      ifm_first_d = RDW'(int'(x_d));
      ifm_next_d  = RDW'((int'(x_d) == OS - 1) ? 0 : int'(x_d) + 1);
      fil_first_d = RDW'(int'(fy_d) * FS);
      fil_last_d  = RDW'(int'(fy_d) * FS + FS - 1);
      nz_first_d  = NZW'(int'(fy_d));
      acc_sel_d   = ACW'((int'(y_d) - int'(fy_d)) * OS + int'(x_d));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      z_q            <= '0;
      y_q            <= '0;
      fy_q           <= '0;
      x_q            <= '0;
      ifm_wr_valid_q <= 1'b0;
      ifm_wr_count_q <= '0;
      ifm_sram_q     <= '0;
      fil_wr_valid_q <= 1'b0;
      fil_wr_count_q <= '0;
      fil_sram_q     <= '0;
      ifm_rd_sel_q   <= 1'b0;
      fil_rd_sel_q   <= 1'b0;
      run_valid_q    <= 1'b0;
      ifm_first_q    <= '0;
      ifm_next_q     <= '0;
      fil_first_q    <= '0;
      fil_last_q     <= '0;
      nz_first_q     <= '0;
      acc_sel_q      <= '0;
    end else begin
      state_q        <= state_d;
      z_q            <= z_d;
      y_q            <= y_d;
      fy_q           <= fy_d;
      x_q            <= x_d;
      ifm_wr_valid_q <= ifm_wr_valid_d;
      ifm_wr_count_q <= ifm_wr_count_d;
      ifm_sram_q     <= ifm_sram_d;
      fil_wr_valid_q <= fil_wr_valid_d;
      fil_wr_count_q <= fil_wr_count_d;
      fil_sram_q     <= fil_sram_d;
      ifm_rd_sel_q   <= ifm_rd_sel_d;
      fil_rd_sel_q   <= fil_rd_sel_d;
      run_valid_q    <= run_valid_d;
      ifm_first_q    <= ifm_first_d;
      ifm_next_q     <= ifm_next_d;
      fil_first_q    <= fil_first_d;
      fil_last_q     <= fil_last_d;
      nz_first_q     <= nz_first_d;
      acc_sel_q      <= acc_sel_d;
    end
  end

  assign ifm_chunk_wr_valid_o       = ifm_wr_valid_q;
  assign ifm_chunk_wr_count_o       = ifm_wr_count_q;
  assign ifm_chunk_rd_sel_o         = ifm_rd_sel_q;
  assign ifm_chunk_wr_sel_o         = ~ifm_rd_sel_q;
  assign ifm_sram_rd_count_o        = ifm_sram_q;
  assign filter_chunk_wr_valid_o    = fil_wr_valid_q;
  assign filter_chunk_wr_count_o    = fil_wr_count_q;
  assign filter_chunk_rd_sel_o      = fil_rd_sel_q;
  assign filter_chunk_wr_sel_o      = ~fil_rd_sel_q;
  assign filter_sram_rd_count_o     = fil_sram_q;
  assign run_valid_o                = run_valid_q;
  assign total_chunk_start_o        = (state_q == S_ISSUE);
  assign rd_ifm_sparsemap_first_o   = ifm_first_q;
  assign rd_ifm_sparsemap_next_o    = ifm_next_q;
  assign rd_fil_sparsemap_first_o   = fil_first_q;
  assign rd_fil_sparsemap_last_o    = fil_last_q;
  assign rd_fil_nonzero_dat_first_o = nz_first_q;
  assign acc_buf_sel_o              = acc_sel_q;
  assign busy_o                     = (state_q != S_IDLE);
  assign done_o                     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_loop_sequencer : directed self-checking bench for                 |
// | conv_loop_sequencer.                                  Revision 1.0         |
// +--------------------------------------------------------------------------+
module tb_conv_loop_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni, start_i, end_i;
  logic       ifm_wr_valid, ifm_wr_sel, ifm_rd_sel;
  logic [2:0] ifm_wr_count;
  logic [5:0] ifm_sram;
  logic       fil_wr_valid, fil_wr_sel, fil_rd_sel;
  logic [2:0] fil_wr_count;
  logic [3:0] fil_sram;
  logic       run_valid, chunk_start, busy, done;
  logic [4:0] ifm_first, ifm_next, fil_first, fil_last;
  logic [3:0] nz_first, acc_sel;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_ftog = 0, burst_bad = 0;
  logic prev_fsel = 1'b0;
  int ifm_len = 0, fil_len = 0;
  int ifm_len_q[$], ifm_src_q[$], fil_len_q[$], fil_src_q[$];
  int y4_q[$];
  int y4_exp[8] = '{12, 13, 14, 15, 8, 9, 10, 11};

  always #5 clk = ~clk;

  conv_loop_sequencer dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_ni),
    .start_i                    (start_i),
    .total_chunk_end_i          (end_i),
    .ifm_chunk_wr_valid_o       (ifm_wr_valid),
    .ifm_chunk_wr_count_o       (ifm_wr_count),
    .ifm_chunk_wr_sel_o         (ifm_wr_sel),
    .ifm_chunk_rd_sel_o         (ifm_rd_sel),
    .ifm_sram_rd_count_o        (ifm_sram),
    .filter_chunk_wr_valid_o    (fil_wr_valid),
    .filter_chunk_wr_count_o    (fil_wr_count),
    .filter_chunk_wr_sel_o      (fil_wr_sel),
    .filter_chunk_rd_sel_o      (fil_rd_sel),
    .filter_sram_rd_count_o     (fil_sram),
    .run_valid_o                (run_valid),
    .total_chunk_start_o        (chunk_start),
    .rd_ifm_sparsemap_first_o   (ifm_first),
    .rd_ifm_sparsemap_next_o    (ifm_next),
    .rd_fil_sparsemap_first_o   (fil_first),
    .rd_fil_sparsemap_last_o    (fil_last),
    .rd_fil_nonzero_dat_first_o (nz_first),
    .acc_buf_sel_o              (acc_sel),
    .busy_o                     (busy),
    .done_o                     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then record pulses and burst shapes seen in this cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_ni) begin
      ifm_len = 0;
      fil_len = 0;
    end else begin
      if (chunk_start) n_start++;
      if (done) n_done++;
      if (fil_rd_sel !== prev_fsel) n_ftog++;
      if (ifm_wr_valid) begin
        if (ifm_len == 0) ifm_src_q.push_back(int'(ifm_sram));
        else if (int'(ifm_sram) != ifm_src_q[$]) burst_bad++;
        if (int'(ifm_wr_count) != ifm_len) burst_bad++;
        if (ifm_wr_sel === ifm_rd_sel) burst_bad++;
        ifm_len++;
      end else if (ifm_len != 0) begin
        ifm_len_q.push_back(ifm_len);
        ifm_len = 0;
      end
      if (fil_wr_valid) begin
        if (fil_len == 0) fil_src_q.push_back(int'(fil_sram));
        else if (int'(fil_sram) != fil_src_q[$]) burst_bad++;
        if (int'(fil_wr_count) != fil_len) burst_bad++;
        if (fil_wr_sel === fil_rd_sel) burst_bad++;
        fil_len++;
      end else if (fil_len != 0) begin
        fil_len_q.push_back(fil_len);
        fil_len = 0;
      end
    end
    prev_fsel = fil_rd_sel;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (chunk_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called in the start-pulse cycle; end is raised d cycles later for one cycle
  task automatic do_end(input int d);
    repeat (d) step();
    end_i = 1'b1;
    step();
    end_i = 1'b0;
  endtask

  initial begin
    bit ok;
    int pidx, lo, hi, t0;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    end_i   = 1'b0;
    repeat (3) step();

    chk("rst_ifm_wr_sel", ifm_wr_sel, 1);
    chk("rst_fil_wr_sel", fil_wr_sel, 1);
    chk("rst_ifm_rd_sel", ifm_rd_sel, 0);
    chk("rst_fil_rd_sel", fil_rd_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_run_valid", run_valid, 0);
    chk("rst_start", chunk_start, 0);
    chk("rst_ifm_wr_valid", ifm_wr_valid, 0);
    chk("rst_fil_wr_valid", fil_wr_valid, 0);
    chk("rst_ifm_next", ifm_next, 0);
    chk("rst_fil_last", fil_last, 0);
    chk("rst_acc_sel", acc_sel, 0);
    chk("rst_ifm_sram", ifm_sram, 0);

    rst_ni = 1'b1;
    step();

    // Preload bursts
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("pre_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      chk("pre_ifm_valid", ifm_wr_valid, 1);
      chk("pre_ifm_count", ifm_wr_count, k);
      chk("pre_fil_valid", fil_wr_valid, 1);
      chk("pre_fil_count", fil_wr_count, k);
      chk("pre_ifm_sram", ifm_sram, 0);
      chk("pre_fil_sram", fil_sram, 0);
      chk("pre_no_run", run_valid, 0);
      step();
    end
    chk("pre_ifm_valid_end", ifm_wr_valid, 0);
    chk("pre_fil_valid_end", fil_wr_valid, 0);
    step();
    chk("swap_no_start", chunk_start, 0);
    step();
    chk("first_start", chunk_start, 1);
    chk("first_ifm_rd_sel", ifm_rd_sel, 1);
    chk("first_fil_rd_sel", fil_rd_sel, 1);
    chk("first_ifm_wr_sel", ifm_wr_sel, 0);
    chk("first_acc", acc_sel, 0);
    chk("first_ifm_first", ifm_first, 0);
    chk("first_ifm_next", ifm_next, 1);
    chk("first_fil_first", fil_first, 0);
    chk("first_fil_last", fil_last, 2);
    chk("first_nz", nz_first, 0);
    chk("first_run_valid", run_valid, 1);
    chk("first_ifm_prefetch", ifm_wr_valid, 1);
    chk("first_ifm_pf_sram", ifm_sram, 1);
    chk("first_fil_prefetch", fil_wr_valid, 1);
    chk("first_fil_pf_sram", fil_sram, 1);

    // Full layer, end returned 3 cycles after every start
    pidx = 0;
    for (int z = 0; z < 2; z++) begin
      for (int y = 0; y < 6; y++) begin
        lo = (y > 3) ? y - 3 : 0;
        hi = (y < 2) ? y : 2;
        for (int fy = lo; fy <= hi; fy++) begin
          for (int x = 0; x < 4; x++) begin
            wait_start(ok);
            chk("pass_start_seen", ok, 1);
            chk("pass_acc", acc_sel, (y - fy) * 4 + x);
            chk("pass_ifm_first", ifm_first, x);
            chk("pass_ifm_next", ifm_next, (x == 3) ? 0 : x + 1);
            chk("pass_fil_first", fil_first, fy * 3);
            chk("pass_fil_last", fil_last, fy * 3 + 2);
            chk("pass_nz", nz_first, fy);
            if (z == 0 && y == 4) y4_q.push_back(int'(acc_sel));
            if (z == 0 && y == 5 && x == 0) begin
              chk("z0y5_ifm_pf_valid", ifm_wr_valid, 1);
              chk("z0y5_ifm_pf_sram", ifm_sram, 6);
              chk("z0y5_fil_rd_sel", fil_rd_sel, 1);
            end
            if (z == 0 && y == 5 && x == 3) begin
              chk("y5x3_next", ifm_next, 0);
              chk("y5x3_fil_first", fil_first, 6);
              chk("y5x3_fil_last", fil_last, 8);
              chk("y5x3_nz", nz_first, 2);
              chk("y5x3_acc", acc_sel, 15);
            end
            if (z == 1 && y == 0 && x == 0) begin
              chk("z1_fil_rd_sel", fil_rd_sel, 0);
              chk("z1_ifm_rd_sel", ifm_rd_sel, 1);
              chk("z1_ifm_wr_sel", ifm_wr_sel, 0);
              chk("z1_no_fil_pf", fil_wr_valid, 0);
            end
            if (pidx == 30) begin
              start_i = 1'b1;
              step();
              start_i = 1'b0;
              do_end(2);
            end else begin
              do_end(3);
            end
            pidx++;
          end
        end
      end
    end
    wait_done(ok);
    chk("done_seen", ok, 1);
    chk("done_run_valid", run_valid, 0);
    chk("done_busy", busy, 1);
    step();
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
    chk("n_start", n_start, 96);
    chk("n_done", n_done, 1);
    chk("fil_rd_sel_toggles", n_ftog, 2);
    chk("y4_count", y4_q.size(), 8);
    for (int i = 0; i < 8 && i < y4_q.size(); i++) chk("y4_acc", y4_q[i], y4_exp[i]);
    chk("ifm_burst_count", ifm_len_q.size(), 12);
    for (int i = 0; i < ifm_len_q.size(); i++) chk("ifm_burst_len", ifm_len_q[i], 8);
    for (int i = 0; i < ifm_src_q.size(); i++) chk("ifm_burst_src", ifm_src_q[i], i);
    chk("fil_burst_count", fil_len_q.size(), 2);
    for (int i = 0; i < fil_len_q.size(); i++) chk("fil_burst_len", fil_len_q[i], 8);
    for (int i = 0; i < fil_src_q.size(); i++) chk("fil_burst_src", fil_src_q[i], i);
    chk("burst_shape_errs", burst_bad, 0);

    // Fast end returns; an end during PRELOAD must be ignored
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    wait_start(ok);
    chk("l2_start_seen", ok, 1);
    chk("l2_acc0", acc_sel, 0);
    chk("l2_first0", ifm_first, 0);
    t0 = cyc;
    for (int x = 1; x < 4; x++) begin
      do_end(1);
      wait_start(ok);
      chk("l2_start_seen", ok, 1);
      chk("l2_acc", acc_sel, x);
    end
    do_end(1);
    wait_start(ok);
    chk("l2_row_start_seen", ok, 1);
    chk("rowwait_gap", cyc - t0, 10);
    chk("l2_y1_acc", acc_sel, 4);
    chk("l2_y1_pf_valid", ifm_wr_valid, 1);
    chk("l2_y1_pf_sram", ifm_sram, 2);

    // Asynchronous reset in WAIT with a prefetch burst running
    step();
    rst_ni = 1'b0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_start", chunk_start, 0);
    chk("arst_run_valid", run_valid, 0);
    chk("arst_ifm_wr_valid", ifm_wr_valid, 0);
    chk("arst_ifm_count", ifm_wr_count, 0);
    chk("arst_ifm_sram", ifm_sram, 0);
    chk("arst_ifm_wr_sel", ifm_wr_sel, 1);
    chk("arst_ifm_rd_sel", ifm_rd_sel, 0);
    chk("arst_fil_rd_sel", fil_rd_sel, 0);
    chk("arst_acc", acc_sel, 0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("replay_ifm_valid", ifm_wr_valid, 1);
    chk("replay_ifm_sram", ifm_sram, 0);
    chk("replay_ifm_count", ifm_wr_count, 0);
    wait_start(ok);
    chk("replay_start_seen", ok, 1);
    chk("replay_acc", acc_sel, 0);
    chk("replay_ifm_next", ifm_next, 1);
    chk("replay_ifm_rd_sel", ifm_rd_sel, 1);
    chk("replay_fil_rd_sel", fil_rd_sel, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
